// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: store-drain FSM states and the store buffer entry layout.
package rv32i_types;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_ISSUE,
        DRAIN_WAIT,
        DRAIN_POP
    } drain_state_t;

    typedef struct packed {
        logic [31:0] store_addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } store_buff_t;

    // The data cache is word addressed; byte position is carried by the mask.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_drain_unit.sv
// Drains committed store-buffer head entries into the data cache write port,
// yielding to loads before a write starts and tracking committed-but-undrained stores.
module store_drain_unit
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 rob_store_commit,
    input  logic                 sb_empty,
    input  logic [31:0]          sb_head_addr,
    input  logic [31:0]          sb_head_wdata,
    input  logic [3:0]           sb_head_wmask,
    output logic                 sb_dequeue,
    input  logic                 load_req,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    output logic [3:0]           dmem_wmask,
    input  logic                 dmem_resp,
    output logic                 drain_busy,
    output logic [CNT_WIDTH-1:0] commit_cnt,
    output logic                 commit_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    drain_state_t         state_q;
    store_buff_t          entry_q;
    logic                 dequeue_q;
    logic                 busy_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 eligible;
    logic                 pop;

    assign eligible = (state_q == DRAIN_IDLE) && (cnt_q != CNT_ZERO) &&
                      !sb_empty && !load_req && !flush;
    assign pop      = (state_q == DRAIN_POP);

    // A commit landing in the POP cycle cancels the decrement; a commit at max is lost and flagged.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rob_store_commit && !pop) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!rob_store_commit && pop && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Flush and load_req only gate the start of a write; once issued it runs to POP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DRAIN_IDLE;
            entry_q   <= '0;
            dequeue_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            dequeue_q <= 1'b0;
            unique case (state_q)
                DRAIN_IDLE: begin
                    if (eligible) begin
                        state_q          <= DRAIN_ISSUE;
                        entry_q.store_addr <= word_align(sb_head_addr);
                        entry_q.wdata    <= sb_head_wdata;
                        entry_q.wmask    <= sb_head_wmask;
                        busy_q           <= 1'b1;
                    end
                end
                DRAIN_ISSUE: begin
                    state_q <= DRAIN_WAIT;
                end
                DRAIN_WAIT: begin
                    if (dmem_resp) begin
                        state_q       <= DRAIN_POP;
                        entry_q.wmask <= 4'b0000;
                        dequeue_q     <= 1'b1;
                    end
                end
                DRAIN_POP: begin
                    state_q <= DRAIN_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= DRAIN_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sb_dequeue      = dequeue_q;
    assign dmem_addr       = entry_q.store_addr;
    assign dmem_wdata      = entry_q.wdata;
    assign dmem_wmask      = entry_q.wmask;
    assign drain_busy      = busy_q;
    assign commit_cnt      = cnt_q;
    assign commit_overflow = ovf_q;

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
- Consumer end of the store buffer. Takes the head entry and writes it to the data cache over the dmem write handshake, then pops the buffer.
- Only stores already committed by the ROB are written; a commit counter tracks them.
- Sits between the store buffer, the ROB commit port and the dmem port, which it shares with the load unit. Loads have priority for that port.

Parameters:
CNT_WIDTH, 6, commit-counter width; must hold store buffer depth (32) plus one.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (asserted when 0)
flush  input  1  pipeline flush (mispredict)
rob_store_commit  input  1  pulse: one store committed this cycle
sb_empty  input  1  store buffer empty
sb_head_addr  input  32  head entry address
sb_head_wdata  input  32  head entry data
sb_head_wmask  input  4  head entry byte mask
sb_dequeue  output  1  pulse: pop head entry
load_req  input  1  load unit wants the dmem port this cycle
dmem_addr  output  32  word-aligned write address
dmem_wdata  output  32  write data
dmem_wmask  output  4  byte mask; nonzero means a write request is active
dmem_resp  input  1  cache write acknowledge
drain_busy  output  1  write in flight (states ISSUE/WAIT/POP)
commit_cnt  output  CNT_WIDTH  committed-but-undrained stores
commit_overflow  output  1  sticky: commit arrived with counter at max

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0; commit_cnt 0; commit_overflow 0.
- All outputs are registered.
- Eligible = state IDLE && commit_cnt!=0 && !sb_empty && !load_req && !flush.

State machine:
- IDLE -> ISSUE when eligible.
  - On the transition, latch dmem_addr={sb_head_addr[31:2],2'b00}, dmem_wdata=sb_head_wdata, dmem_wmask=sb_head_wmask.
- ISSUE -> WAIT after exactly one cycle.
  - dmem_wmask is held nonzero through ISSUE and WAIT; addr, data and mask stay stable.
- WAIT -> POP on dmem_resp.
  - dmem_resp is never sampled in the ISSUE cycle; it is only valid from the cycle after ISSUE.
  - Entering POP clears dmem_wmask to 0.
- POP: sb_dequeue=1 for exactly this one cycle; commit_cnt decrements by 1. POP -> IDLE.
- Minimum spacing between writes: IDLE, ISSUE, WAIT(resp), POP, i.e. 4 cycles per store when the cache acknowledges on the first cycle after ISSUE.
- Latency: eligible at cycle N -> dmem_wmask!=0 at N+1.

Commit counter:
- rob_store_commit in the same cycle as the POP decrement: net change 0.
- Commit with commit_cnt==2^CNT_WIDTH-1: counter holds and commit_overflow sets. It clears only on reset.
- Decrement never occurs at 0; POP is only reachable with commit_cnt>=1.

Load priority:
- load_req only blocks the IDLE->ISSUE transition.
- Once ISSUE is entered, the write owns the port until POP; load_req is ignored for that write.

Flush:
- Committed stores in the buffer survive a flush; the store buffer clears only uncommitted entries.
- Flush in IDLE: stays IDLE for that cycle; commit_cnt unchanged.
- Flush in ISSUE/WAIT/POP: the write is not cancelled. It completes normally, sb_dequeue pulses and commit_cnt decrements.
- A flush in the same cycle as rob_store_commit still counts the commit.
- sb_empty while commit_cnt!=0 (buffer not yet updated): wait in IDLE. This is not an error.

Mid-operation reset:
- Return to IDLE at once with dmem_wmask=0. Any pending dmem_resp is dropped.

Decomposition:
- rv32i_types gains a drain_state_t enum {DRAIN_IDLE, DRAIN_ISSUE, DRAIN_WAIT, DRAIN_POP}.
- rv32i_types also gains the existing store_buff_t, reused for the latched head entry (store_addr, wdata, wmask).
- No sub-module; counter and FSM live in one module.

Test Plan:
- Reset release, 2 commits, buffer holds {0x0000_1006, 0xDEAD_BEEF, 4'b1100}:
  - dmem_addr=0x0000_1004, wdata 0xDEADBEEF, wmask 4'b1100 one cycle after eligible.
  - resp 3 cycles later -> sb_dequeue single pulse; commit_cnt 2->1.
- load_req held high 5 cycles with commit_cnt=1 and buffer non-empty:
  - dmem_wmask stays 0 throughout; request appears the cycle after load_req drops.
- rob_store_commit in the POP cycle with commit_cnt=1 -> commit_cnt stays 1; next store issues.
- Flush asserted in WAIT:
  - Request held; resp arrives -> sb_dequeue pulses; commit_cnt decrements; FSM returns to IDLE.
- 63 commits then one more with no drain:
  - commit_cnt=63; commit_overflow=1 and remains 1 until rst=0.
- rst=0 during WAIT:
  - Next cycle dmem_wmask=0, drain_busy=0, commit_cnt=0; a late dmem_resp produces no sb_dequeue.
